// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter: FSM state encoding
// and port identifiers.
package sram_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bus bundle between two requesting masters, the arbiter and the SRAM controller.
// slave = arbiter view; master = the surrounding requesters plus SRAM controller.
interface sram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_wrEn;
    logic              p0_rdEn;
    logic [ADDR_W-1:0] p0_address;
    logic [DATA_W-1:0] p0_writeData;
    logic [DATA_W-1:0] p0_readData;
    logic              p0_ready;

    logic              p1_wrEn;
    logic              p1_rdEn;
    logic [ADDR_W-1:0] p1_address;
    logic [DATA_W-1:0] p1_writeData;
    logic [DATA_W-1:0] p1_readData;
    logic              p1_ready;

    logic              mem_wrEn;
    logic              mem_rdEn;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writeData;
    logic [DATA_W-1:0] mem_readData;
    logic              mem_ready;

    modport slave (
        input  p0_wrEn, p0_rdEn, p0_address, p0_writeData,
        output p0_readData, p0_ready,
        input  p1_wrEn, p1_rdEn, p1_address, p1_writeData,
        output p1_readData, p1_ready,
        output mem_wrEn, mem_rdEn, mem_address, mem_writeData,
        input  mem_readData, mem_ready
    );

    modport master (
        output p0_wrEn, p0_rdEn, p0_address, p0_writeData,
        input  p0_readData, p0_ready,
        output p1_wrEn, p1_rdEn, p1_address, p1_writeData,
        input  p1_readData, p1_ready,
        input  mem_wrEn, mem_rdEn, mem_address, mem_writeData,
        output mem_readData, mem_ready
    );
endinterface

// File: rtl/sram_arb_pick.sv
// Grant selection between two requesters. Macro SRAM_ARB_ROUND_ROBIN_EN switches
// simultaneous-request resolution from fixed port-0 priority to alternating.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic pick
);

`ifndef SRAM_ARB_ROUND_ROBIN_EN
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;
`endif

    // Choose the port to serve; a sole requester always wins.
    always_comb begin
        pick = PORT0;
        if (req0 && req1) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            pick = (last_grant == PORT0) ? PORT1 : PORT0;
`else
            pick = PORT0;
`endif
        end else if (req1) begin
            pick = PORT1;
        end else begin
            pick = PORT0;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single SRAM controller: latches one request,
// forwards it to the controller and routes the completion back to its owner.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  bus,
    output logic           busy,
    output logic           grant
);

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              cool_q, cool_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              req0_s, req1_s, pick_s, done_s, sel_wr_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    assign req0_s = bus.p0_wrEn | bus.p0_rdEn;
    assign req1_s = bus.p1_wrEn | bus.p1_rdEn;

    sram_arb_pick u_pick (
        .req0       (req0_s),
        .req1       (req1_s),
        .last_grant (grant_q),
        .pick       (pick_s)
    );

    // Completion is suppressed during reset so an abandoned transfer never signals ready.
    assign done_s = (state_q == ST_BUSY) && bus.mem_ready && !rst;

    // Operand mux for the port chosen this cycle; a write flag beats a read flag.
    always_comb begin
        sel_wr_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        if (pick_s == PORT1) begin
            sel_wr_s    = bus.p1_wrEn;
            sel_addr_s  = bus.p1_address;
            sel_wdata_s = bus.p1_writeData;
        end else begin
            sel_wr_s    = bus.p0_wrEn;
            sel_addr_s  = bus.p0_address;
            sel_wdata_s = bus.p0_writeData;
        end
    end

    // Next-state logic; cool_q skips one IDLE cycle so a stale request is not re-taken.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        mem_wr_d = mem_wr_q;
        mem_rd_d = mem_rd_q;
        cool_d   = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (!cool_q && (req0_s || req1_s)) begin
                    state_d  = ST_BUSY;
                    grant_d  = pick_s;
                    mem_wr_d = sel_wr_s;
                    mem_rd_d = !sel_wr_s;
                    addr_d   = sel_addr_s;
                    wdata_d  = sel_wdata_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready) begin
                    state_d  = ST_IDLE;
                    mem_wr_d = 1'b0;
                    mem_rd_d = 1'b0;
                    cool_d   = 1'b1;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                mem_wr_d = 1'b0;
                mem_rd_d = 1'b0;
            end
        endcase
    end

    // State and transfer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= PORT1;
            mem_wr_q <= 1'b0;
            mem_rd_q <= 1'b0;
            cool_q   <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            mem_wr_q <= mem_wr_d;
            mem_rd_q <= mem_rd_d;
            cool_q   <= cool_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.mem_wrEn      = mem_wr_q;
    assign bus.mem_rdEn      = mem_rd_q;
    assign bus.mem_address   = addr_q;
    assign bus.mem_writeData = wdata_q;

    assign bus.p0_ready    = done_s && (grant_q == PORT0);
    assign bus.p1_ready    = done_s && (grant_q == PORT1);
    assign bus.p0_readData = (grant_q == PORT0) ? bus.mem_readData : {DATA_W{1'b0}};
    assign bus.p1_readData = (grant_q == PORT1) ? bus.mem_readData : {DATA_W{1'b0}};

    assign busy  = (state_q == ST_BUSY);
    assign grant = grant_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed scenarios followed by random two-master traffic against a
// cycle-level reference of the arbitration rules.
module tb_sram_arbiter;

    logic clk;
    logic rst;
    logic busy;
    logic grant;
    int   total;
    int   bad;

    sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_inputs();
        bus.p0_wrEn = 1'b0; bus.p0_rdEn = 1'b0; bus.p0_address = 32'h0; bus.p0_writeData = 32'h0;
        bus.p1_wrEn = 1'b0; bus.p1_rdEn = 1'b0; bus.p1_address = 32'h0; bus.p1_writeData = 32'h0;
        bus.mem_ready = 1'b0; bus.mem_readData = 32'h0;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        zero_inputs();
        smp();
        cyc();
        rst = 1'b0;
        smp();
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 1'b1);
        chk("rst_mem_wr", bus.mem_wrEn, 1'b0);
        chk("rst_mem_rd", bus.mem_rdEn, 1'b0);
        chk("rst_mem_addr", bus.mem_address, 32'h0);
        chk("rst_mem_wdata", bus.mem_writeData, 32'h0);
        chk("rst_p0_ready", bus.p0_ready, 1'b0);
        chk("rst_p1_ready", bus.p1_ready, 1'b0);
    endtask

    // Reference arbitration rule for simultaneous / sole requests.
    function automatic bit arb(input bit r0, input bit r1, input bit last);
        if (r0 && r1) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            return ~last;
`else
            return last & 1'b0;
`endif
        end
        return r0 ? 1'b0 : 1'b1;
    endfunction

    bit          m_busy, m_grant, m_cool, m_wr, w, mr, er;
    int          m_lat, k;
    logic [31:0] m_addr, m_wdata, rdata;
    bit          act[2], stale[2], drop[2], rq_wr[2], rq_rd[2], l_wr[2], l_rd[2];
    logic [31:0] rq_addr[2], rq_data[2];
    bit          exp_g[4];
    int          op;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        zero_inputs();
        repeat (3) cyc();
        do_reset();

        // Single p0 read with five-cycle SRAM latency.
        cyc();
        bus.p0_rdEn = 1'b1; bus.p0_address = 32'h0000_0010;
        smp();
        chk("r31_idle_busy", busy, 1'b0);
        cyc(); smp();
        chk("r31_mem_rd", bus.mem_rdEn, 1'b1);
        chk("r31_mem_wr", bus.mem_wrEn, 1'b0);
        chk("r31_mem_addr", bus.mem_address, 32'h0000_0010);
        chk("r31_grant", grant, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(); smp();
            chk("r31_wait_ready", bus.p0_ready, 1'b0);
        end
        cyc();
        bus.mem_ready = 1'b1; bus.mem_readData = 32'hDEAD_BEEF;
        smp();
        chk("r31_p0_ready", bus.p0_ready, 1'b1);
        chk("r31_p0_data", bus.p0_readData, 32'hDEAD_BEEF);
        chk("r31_p1_ready", bus.p1_ready, 1'b0);
        cyc();
        bus.mem_ready = 1'b0; bus.p0_rdEn = 1'b0;
        smp();
        chk("r31_ready_pulse", bus.p0_ready, 1'b0);
        chk("r31_done_busy", busy, 1'b0);
        chk("r31_done_rd", bus.mem_rdEn, 1'b0);

        // Simultaneous p0 write / p1 read.
        do_reset();
        cyc();
        bus.p0_wrEn = 1'b1; bus.p0_address = 32'h20; bus.p0_writeData = 32'h1234_5678;
        bus.p1_rdEn = 1'b1; bus.p1_address = 32'h40;
        cyc(); smp();
        chk("r32_first_grant", grant, 1'b0);
        chk("r32_first_wr", bus.mem_wrEn, 1'b1);
        chk("r32_first_addr", bus.mem_address, 32'h20);
        chk("r32_first_wdata", bus.mem_writeData, 32'h1234_5678);
        cyc();
        bus.mem_ready = 1'b1;
        smp();
        chk("r32_p0_ready", bus.p0_ready, 1'b1);
        chk("r32_p1_quiet", bus.p1_ready, 1'b0);
        cyc();
        bus.mem_ready = 1'b0; bus.p0_wrEn = 1'b0;
        smp();
        chk("r32_gap_busy", busy, 1'b0);
        cyc(); smp();
        chk("r32_cool_busy", busy, 1'b0);
        cyc(); smp();
        chk("r32_second_grant", grant, 1'b1);
        chk("r32_second_rd", bus.mem_rdEn, 1'b1);
        chk("r32_second_addr", bus.mem_address, 32'h40);
        cyc();
        bus.mem_ready = 1'b1; bus.mem_readData = 32'hCAFE_0042;
        smp();
        chk("r32_p1_ready", bus.p1_ready, 1'b1);
        chk("r32_p0_quiet", bus.p0_ready, 1'b0);
        chk("r32_p1_data", bus.p1_readData, 32'hCAFE_0042);
        cyc();
        bus.mem_ready = 1'b0; bus.p1_rdEn = 1'b0;

        // Both ports requesting continuously for four transfers.
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        cyc();
        bus.p0_rdEn = 1'b1; bus.p0_address = 32'h100;
        bus.p1_rdEn = 1'b1; bus.p1_address = 32'h200;
        smp();
        for (int n = 0; n < 4; n++) begin
            k = 0;
            do begin
                cyc(); smp(); k++;
            end while (!busy && k < 8);
            chk("r33_start", busy, 1'b1);
            chk("r33_grant", grant, exp_g[n]);
            cyc();
            bus.mem_ready = 1'b1;
            smp();
            chk("r33_p0_ready", bus.p0_ready, exp_g[n] == 1'b0);
            chk("r33_p1_ready", bus.p1_ready, exp_g[n] == 1'b1);
            cyc();
            bus.mem_ready = 1'b0;
            smp();
            chk("r33_ret_busy", busy, 1'b0);
            cyc(); smp();
            chk("r33_no_stale_sample", busy, 1'b0);
        end
        bus.p0_rdEn = 1'b0; bus.p1_rdEn = 1'b0;

        // Reset two cycles into a p1 transfer.
        do_reset();
        cyc();
        bus.p1_rdEn = 1'b1; bus.p1_address = 32'h80;
        cyc(); smp();
        chk("r34_busy", busy, 1'b1);
        cyc();
        rst = 1'b1; bus.mem_ready = 1'b1;
        smp();
        chk("r34_rst_no_ready", bus.p1_ready, 1'b0);
        cyc();
        rst = 1'b0; bus.mem_ready = 1'b0; bus.p1_rdEn = 1'b0;
        smp();
        chk("r34_busy_after", busy, 1'b0);
        chk("r34_rd_after", bus.mem_rdEn, 1'b0);
        chk("r34_grant_after", grant, 1'b1);
        chk("r34_p1_ready_after", bus.p1_ready, 1'b0);

        // Spurious mem_ready while idle.
        cyc();
        bus.mem_ready = 1'b1;
        smp();
        chk("r35_p0_ready", bus.p0_ready, 1'b0);
        chk("r35_p1_ready", bus.p1_ready, 1'b0);
        cyc();
        bus.mem_ready = 1'b0;
        smp();
        chk("r35_busy", busy, 1'b0);

        // wrEn and rdEn together is a write.
        cyc();
        bus.p0_wrEn = 1'b1; bus.p0_rdEn = 1'b1; bus.p0_address = 32'h08; bus.p0_writeData = 32'h55;
        cyc(); smp();
        chk("r36_wr", bus.mem_wrEn, 1'b1);
        chk("r36_rd", bus.mem_rdEn, 1'b0);
        chk("r36_addr", bus.mem_address, 32'h08);
        cyc();
        bus.mem_ready = 1'b1;
        smp();
        chk("r36_p0_ready", bus.p0_ready, 1'b1);
        cyc();
        bus.mem_ready = 1'b0; bus.p0_wrEn = 1'b0; bus.p0_rdEn = 1'b0;

        // Random traffic from both masters against the reference.
        do_reset();
        m_busy = 1'b0; m_grant = 1'b1; m_cool = 1'b0; m_wr = 1'b0; m_lat = 0;
        m_addr = 32'h0; m_wdata = 32'h0;
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; stale[p] = 1'b0; drop[p] = 1'b0;
            rq_wr[p] = 1'b0; rq_rd[p] = 1'b0; rq_addr[p] = 32'h0; rq_data[p] = 32'h0;
        end
        for (int c = 0; c < 500; c++) begin
            cyc();
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && !stale[p] && $urandom_range(2) == 0) begin
                    act[p]  = 1'b1;
                    drop[p] = 1'b0;
                    op      = int'($urandom_range(3));
                    rq_wr[p] = (op == 0) || (op == 2);
                    rq_rd[p] = (op != 0);
                    rq_addr[p] = $urandom & 32'hFFFF_FFFC;
                    rq_data[p] = $urandom;
                end else if (act[p] && m_busy && (m_grant == p[0]) && $urandom_range(3) == 0) begin
                    drop[p] = 1'b1;
                end
                if (stale[p] || (act[p] && !drop[p])) begin
                    l_wr[p] = rq_wr[p]; l_rd[p] = rq_rd[p];
                end else begin
                    l_wr[p] = 1'b0; l_rd[p] = 1'b0;
                end
            end
            bus.p0_wrEn = l_wr[0]; bus.p0_rdEn = l_rd[0];
            bus.p0_address = rq_addr[0]; bus.p0_writeData = rq_data[0];
            bus.p1_wrEn = l_wr[1]; bus.p1_rdEn = l_rd[1];
            bus.p1_address = rq_addr[1]; bus.p1_writeData = rq_data[1];
            er = m_busy && (m_lat == 0);
            mr = er || (!m_busy && $urandom_range(5) == 0);
            rdata = $urandom;
            bus.mem_ready = mr; bus.mem_readData = rdata;
            smp();
            chk("rnd_busy", busy, m_busy);
            chk("rnd_grant", grant, m_grant);
            chk("rnd_mem_wr", bus.mem_wrEn, m_busy && m_wr);
            chk("rnd_mem_rd", bus.mem_rdEn, m_busy && !m_wr);
            if (m_busy) begin
                chk("rnd_mem_addr", bus.mem_address, m_addr);
                chk("rnd_mem_wdata", bus.mem_writeData, m_wdata);
            end
            chk("rnd_p0_ready", bus.p0_ready, er && (m_grant == 1'b0));
            chk("rnd_p1_ready", bus.p1_ready, er && (m_grant == 1'b1));
            if (er && m_grant == 1'b0) chk("rnd_p0_data", bus.p0_readData, rdata);
            if (er && m_grant == 1'b1) chk("rnd_p1_data", bus.p1_readData, rdata);
            stale[0] = 1'b0; stale[1] = 1'b0;
            if (m_busy) begin
                if (m_lat == 0) begin
                    m_busy = 1'b0;
                    m_cool = 1'b1;
                    act[m_grant] = 1'b0;
                    stale[m_grant] = ($urandom_range(1) == 1);
                end else begin
                    m_lat--;
                end
            end else if (m_cool) begin
                m_cool = 1'b0;
            end else if (l_wr[0] || l_rd[0] || l_wr[1] || l_rd[1]) begin
                w       = arb(l_wr[0] || l_rd[0], l_wr[1] || l_rd[1], m_grant);
                m_busy  = 1'b1;
                m_grant = w;
                m_wr    = l_wr[w];
                m_addr  = rq_addr[w];
                m_wdata = rq_data[w];
                m_lat   = int'($urandom_range(3));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, data word width of all data ports.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports p0_wrEn, p0_rdEn  input  1 each  port-0 (MEM stage) write/read request, level, held until p0_ready.
REQ-006 SHALL have ports p0_address  input  ADDR_W, and p0_writeData  input  DATA_W  port-0 request operands.
REQ-007 SHALL have ports p0_readData  output  DATA_W, and p0_ready  output  1  port-0 completion data and one-cycle completion pulse.
REQ-008 SHALL have ports p1_wrEn, p1_rdEn, p1_address, p1_writeData, p1_readData, p1_ready with the same widths and meaning for port 1 (secondary master).
REQ-009 SHALL have ports mem_wrEn, mem_rdEn  output  1; mem_address  output  ADDR_W; mem_writeData  output  DATA_W  request to the SRAM controller.
REQ-010 SHALL have ports mem_readData  input  DATA_W, and mem_ready  input  1  SRAM controller completion pulse and data.
REQ-011 SHALL have ports busy  output  1  (transfer in flight) and grant  output  1  (port currently or last served).

Function
REQ-012 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-013 In IDLE with any pN_wrEn|pN_rdEn high, SHALL select one port, register its op, address and writeData, set grant, and enter BUSY next cycle.
REQ-014 In BUSY, SHALL drive mem_* from the registered values only; requester inputs are ignored.
REQ-015 Latency: a request first seen in IDLE at cycle t SHALL appear on mem_wrEn/mem_rdEn at cycle t+1.
REQ-016 In BUSY with mem_ready high, SHALL pulse p<grant>_ready the same cycle (combinational), drop mem_wrEn/mem_rdEn, and return to IDLE next cycle.
REQ-017 pN_readData SHALL equal mem_readData while grant==N; it is valid only in the pN_ready cycle.
REQ-018 The non-granted port's ready SHALL stay low at all times.
REQ-019 A port asserting wrEn and rdEn together SHALL be treated as a write.
REQ-020 mem_ready while IDLE SHALL be ignored; no pN_ready is generated.
REQ-021 A requester dropping its request while BUSY SHALL NOT abort the transfer; completion still pulses its ready.
REQ-022 The completing port's request, still high in the cycle after ready, SHALL NOT be sampled; IDLE sampling occurs one cycle after return.
REQ-023 busy SHALL be 1 exactly in BUSY.

Reset
REQ-024 On rst, SHALL enter IDLE; busy=0, grant=1, mem_wrEn=mem_rdEn=0, mem_address=0, mem_writeData=0, p0_ready=p1_ready=0.
REQ-025 A reset during BUSY SHALL abandon the transfer without generating any pN_ready.

Configuration
REQ-026 Macro SRAM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-027 With SRAM_ARB_ROUND_ROBIN_EN defined, on simultaneous requests SHALL grant the port not equal to the registered grant; a sole requester always wins.
REQ-028 Without SRAM_ARB_ROUND_ROBIN_EN, port 0 SHALL always win simultaneous requests (fixed priority).

Structure
REQ-029 FSM state encodings and the port-ID constants SHALL live in the shared package sram_arb_pkg.
REQ-030 Grant selection SHALL be a sub-module sram_arb_pick (inputs: two request bits, last grant; output: chosen port); all other logic stays in sram_arbiter.

Verification
REQ-031 Single p0 read of 0x0000_0010, mem_ready after 5 cycles, mem_readData=0xDEAD_BEEF -> mem_rdEn at t+1, p0_ready one cycle, p0_readData=0xDEAD_BEEF, p1_ready stays 0.
REQ-032 p0 write 0x20/0x1234_5678 and p1 read 0x40 requested in the same cycle -> p0 served first, then p1; mem_address sequence 0x20 then 0x40.
REQ-033 Both ports requesting continuously for 4 transfers -> grants 0,1,0,1 with SRAM_ARB_ROUND_ROBIN_EN; 0,0,0,0 without it.
REQ-034 rst asserted 2 cycles into a p1 transfer -> next cycle busy=0, mem_rdEn=0, grant=1, no p1_ready.
REQ-035 Spurious mem_ready in IDLE -> no pN_ready, FSM stays IDLE.
REQ-036 p0 asserts wrEn and rdEn together with address 0x08 -> mem_wrEn=1, mem_rdEn=0, mem_address=0x08.
